// File: rtl/group_dispatcher_pkg.sv
// Shared widths and helpers for the coprocessor group dispatcher and its per-group result buffers.
package group_dispatcher_pkg;

  localparam int unsigned X_ID_WIDTH = 4;

  // Width of a per-group credit counter that must hold 0..max_outstanding.
  function automatic int unsigned cnt_width(input int unsigned max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

  // Index width that stays legal for a single-entry range.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/group_result_fifo.sv
// Per-group ID FIFO plus tagged result FIFO; reports occupancy (credits) and done-without-ID errors.
module group_result_fifo
  import group_dispatcher_pkg::*;
#(
  parameter int unsigned  Depth    = 2,
  parameter int unsigned  OutWidth = 64,
  parameter int unsigned  IdWidth  = X_ID_WIDTH,
  localparam int unsigned CntW     = cnt_width(Depth)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                push_i,
  input  logic [IdWidth-1:0]  id_i,
  input  logic                done_i,
  input  logic [OutWidth-1:0] data_i,
  input  logic                pop_i,
  output logic                res_valid_o,
  output logic [OutWidth-1:0] res_data_o,
  output logic [IdWidth-1:0]  res_id_o,
  output logic [CntW-1:0]     cnt_o,
  output logic                err_o
);

  localparam int unsigned PtrW = idx_width(Depth);

  typedef struct packed {
    logic [OutWidth-1:0] out_data;
    logic [IdWidth-1:0]  instr_id;
  } group_result_t;

  logic [IdWidth-1:0] id_mem_q  [Depth];
  group_result_t      res_mem_q [Depth];
  logic [PtrW-1:0]    id_wr_q, id_rd_q, res_wr_q, res_rd_q;
  logic [CntW-1:0]    id_cnt_q, res_cnt_q;
  logic               err_q;
  logic               done_ok, done_err;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Dones during a flush belong to killed work and are silently dropped.
  assign done_ok  = done_i && !flush_i && (id_cnt_q != '0);
  assign done_err = done_i && !flush_i && (id_cnt_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        id_mem_q[i]  <= '0;
        res_mem_q[i] <= '0;
      end
      id_wr_q   <= '0;
      id_rd_q   <= '0;
      res_wr_q  <= '0;
      res_rd_q  <= '0;
      id_cnt_q  <= '0;
      res_cnt_q <= '0;
    end else if (flush_i) begin
      id_wr_q   <= '0;
      id_rd_q   <= '0;
      res_wr_q  <= '0;
      res_rd_q  <= '0;
      id_cnt_q  <= '0;
      res_cnt_q <= '0;
    end else begin
      if (push_i) begin
        id_mem_q[id_wr_q] <= id_i;
        id_wr_q           <= ptr_inc(id_wr_q);
      end
      if (done_ok) begin
        res_mem_q[res_wr_q] <= '{out_data: data_i, instr_id: id_mem_q[id_rd_q]};
        res_wr_q            <= ptr_inc(res_wr_q);
        id_rd_q             <= ptr_inc(id_rd_q);
      end
      if (pop_i) begin
        res_rd_q <= ptr_inc(res_rd_q);
      end
      id_cnt_q  <= id_cnt_q + CntW'(push_i) - CntW'(done_ok);
      res_cnt_q <= res_cnt_q + CntW'(done_ok) - CntW'(pop_i);
    end
  end

  // Sticky until reset; a flush does not clear it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (done_err) begin
      err_q <= 1'b1;
    end
  end

  assign res_valid_o = (res_cnt_q != '0);
  assign res_data_o  = res_mem_q[res_rd_q].out_data;
  assign res_id_o    = res_mem_q[res_rd_q].instr_id;
  assign cnt_o       = id_cnt_q + res_cnt_q;
  assign err_o       = err_q;

endmodule

// File: rtl/group_dispatcher.sv
// Credit-based dispatcher to NumGroup execution groups with tagged result buffering and
// round-robin writeback whose grant is held while the core stalls.
module group_dispatcher
  import group_dispatcher_pkg::*;
#(
  parameter int unsigned NumGroup                  = 4,
  parameter int unsigned OpcodeWidth               = 6,
  parameter int unsigned OutWidth                  = 64,
  parameter int unsigned IdWidth                   = X_ID_WIDTH,
  parameter int unsigned MaxOutstanding            = 2,
  parameter int unsigned OpcodeBound [NumGroup+1]  = '{0, 8, 16, 24, 32}
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic                               exec_i,
  input  logic [OpcodeWidth-1:0]             opcode_i,
  input  logic [IdWidth-1:0]                 instr_id_i,
  input  logic                               fill_vld_i,
  input  logic                               pick_vld_i,
  output logic                               accept_o,
  output logic                               invalid_instr_o,
  output logic [NumGroup-1:0]                grp_exec_o,
  output logic [NumGroup-1:0]                grp_fill_vld_o,
  output logic                               grp_flush_o,
  input  logic [NumGroup-1:0]                grp_done_i,
  input  logic [NumGroup-1:0][OutWidth-1:0]  grp_out_data_i,
  output logic [OutWidth-1:0]                pick_data_o,
  output logic                               wb_valid_o,
  input  logic                               wb_ready_i,
  output logic [OutWidth-1:0]                wb_data_o,
  output logic [IdWidth-1:0]                 wb_id_o,
  output logic                               err_o
);

  localparam int unsigned IdxW = idx_width(NumGroup);
  localparam int unsigned CntW = cnt_width(MaxOutstanding);

  logic [NumGroup-1:0] hit, res_valid, pop, fifo_err;
  logic [IdxW-1:0]     grp_idx, gnt, gnt_q, rr_q;
  logic                any_hit, lock_q, found, wb_hs;
  logic [OutWidth-1:0] res_data [NumGroup];
  logic [IdWidth-1:0]  res_id   [NumGroup];
  logic [CntW-1:0]     cnt      [NumGroup];
  logic                unused_pick_vld;

  // Opcode range decode.
  always_comb begin
    hit     = '0;
    grp_idx = '0;
    for (int unsigned g = 0; g < NumGroup; g++) begin
      if ((32'(opcode_i) >= OpcodeBound[g]) && (32'(opcode_i) < OpcodeBound[g+1])) begin
        hit[g]  = 1'b1;
        grp_idx = IdxW'(g);
      end
    end
  end

  assign any_hit         = |hit;
  assign invalid_instr_o = !any_hit;
  assign accept_o        = exec_i && any_hit && !flush_i &&
                           (cnt[grp_idx] < CntW'(MaxOutstanding));
  assign grp_exec_o      = {NumGroup{accept_o}} & hit;
  assign grp_fill_vld_o  = {NumGroup{fill_vld_i}} & hit;
  assign grp_flush_o     = flush_i;

  // Pick is a plain mux of the decoded group's output; the strobe only qualifies it for the core.
  assign pick_data_o     = any_hit ? grp_out_data_i[grp_idx] : '0;
  assign unused_pick_vld = pick_vld_i;

  for (genvar g = 0; g < NumGroup; g++) begin : gen_grp
    assign pop[g] = wb_hs && (gnt == IdxW'(g));

    group_result_fifo #(
      .Depth    (MaxOutstanding),
      .OutWidth (OutWidth),
      .IdWidth  (IdWidth)
    ) i_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .push_i      (grp_exec_o[g]),
      .id_i        (instr_id_i),
      .done_i      (grp_done_i[g]),
      .data_i      (grp_out_data_i[g]),
      .pop_i       (pop[g]),
      .res_valid_o (res_valid[g]),
      .res_data_o  (res_data[g]),
      .res_id_o    (res_id[g]),
      .cnt_o       (cnt[g]),
      .err_o       (fifo_err[g])
    );
  end

  // Round-robin from rr_q upward, wrapping; a stalled grant is held via lock_q.
  always_comb begin
    gnt   = gnt_q;
    found = lock_q;
    for (int unsigned i = 0; i < NumGroup; i++) begin
      if (!found && res_valid[i] && (IdxW'(i) >= rr_q)) begin
        gnt   = IdxW'(i);
        found = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NumGroup; i++) begin
      if (!found && res_valid[i]) begin
        gnt   = IdxW'(i);
        found = 1'b1;
      end
    end
  end

  assign wb_valid_o = (|res_valid) && !flush_i;
  assign wb_hs      = wb_valid_o && wb_ready_i;
  assign wb_data_o  = wb_valid_o ? res_data[gnt] : '0;
  assign wb_id_o    = wb_valid_o ? res_id[gnt] : '0;
  assign err_o      = |fifo_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q   <= '0;
      gnt_q  <= '0;
      lock_q <= 1'b0;
    end else if (flush_i) begin
      rr_q   <= '0;
      gnt_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      lock_q <= wb_valid_o && !wb_ready_i;
      gnt_q  <= gnt;
      if (wb_hs) begin
        rr_q <= (gnt == IdxW'(NumGroup - 1)) ? '0 : gnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_group_dispatcher.sv
// Directed bench for group_dispatcher: queue-based reference model checked every cycle plus literal checkpoints.
module tb_group_dispatcher;
  import group_dispatcher_pkg::*;

  localparam int NG   = 4;
  localparam int OW   = 64;
  localparam int IW   = X_ID_WIDTH;
  localparam int OPW  = 6;
  localparam int MAXO = 2;
  localparam int BOUND [NG+1] = '{0, 8, 16, 24, 32};

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   flush_i, exec_i, fill_vld_i, pick_vld_i, wb_ready_i;
  logic [OPW-1:0]         opcode_i;
  logic [IW-1:0]          instr_id_i;
  logic                   accept_o, invalid_instr_o, grp_flush_o, wb_valid_o, err_o;
  logic [NG-1:0]          grp_exec_o, grp_fill_vld_o, grp_done_i;
  logic [NG-1:0][OW-1:0]  grp_out_data_i;
  logic [OW-1:0]          pick_data_o, wb_data_o;
  logic [IW-1:0]          wb_id_o;

  int checks = 0;
  int errors = 0;

  group_dispatcher #(
    .NumGroup       (NG),
    .OpcodeWidth    (OPW),
    .OutWidth       (OW),
    .IdWidth        (IW),
    .MaxOutstanding (MAXO)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .exec_i          (exec_i),
    .opcode_i        (opcode_i),
    .instr_id_i      (instr_id_i),
    .fill_vld_i      (fill_vld_i),
    .pick_vld_i      (pick_vld_i),
    .accept_o        (accept_o),
    .invalid_instr_o (invalid_instr_o),
    .grp_exec_o      (grp_exec_o),
    .grp_fill_vld_o  (grp_fill_vld_o),
    .grp_flush_o     (grp_flush_o),
    .grp_done_i      (grp_done_i),
    .grp_out_data_i  (grp_out_data_i),
    .pick_data_o     (pick_data_o),
    .wb_valid_o      (wb_valid_o),
    .wb_ready_i      (wb_ready_i),
    .wb_data_o       (wb_data_o),
    .wb_id_o         (wb_id_o),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  // Reference model: per-group queues of pending IDs and tagged results.
  typedef struct {
    logic [63:0] d;
    int          id;
  } res_t;

  int      idq  [NG][$];
  res_t    resq [NG][$];
  int      rr, lockg, e_g, e_wbg;
  bit      merr, e_acc;
  res_t    r_tmp;
  logic [NG-1:0] exp_hit;
  logic [63:0]   x_pick, x_wbd, x_wbi;

  function automatic void model_clear(input bit clr_err);
    for (int g = 0; g < NG; g++) begin
      idq[g].delete();
      resq[g].delete();
    end
    rr    = 0;
    lockg = -1;
    if (clr_err) merr = 1'b0;
  endfunction

  initial begin
    model_clear(1'b1);
    forever begin
      @(negedge clk_i);
      if (!rst_ni) model_clear(1'b1);
      e_g = -1;
      for (int g = 0; g < NG; g++)
        if (int'(opcode_i) >= BOUND[g] && int'(opcode_i) < BOUND[g+1]) e_g = g;
      e_acc   = 1'b0;
      exp_hit = '0;
      x_pick  = '0;
      if (e_g >= 0) begin
        e_acc = exec_i && !flush_i && rst_ni && (idq[e_g].size() + resq[e_g].size() < MAXO);
        exp_hit[e_g] = 1'b1;
        x_pick = grp_out_data_i[e_g];
      end
      e_wbg = -1;
      if (rst_ni && !flush_i) begin
        if (lockg >= 0) e_wbg = lockg;
        else
          for (int k = 0; k < NG; k++)
            if (e_wbg < 0 && resq[(rr + k) % NG].size() > 0) e_wbg = (rr + k) % NG;
      end
      x_wbd = '0;
      x_wbi = '0;
      if (e_wbg >= 0) begin
        x_wbd = resq[e_wbg][0].d;
        x_wbi = 64'(resq[e_wbg][0].id);
      end
      chk("accept",    accept_o, e_acc);
      chk("invalid",   invalid_instr_o, e_g < 0);
      chk("grp_exec",  grp_exec_o, e_acc ? exp_hit : '0);
      chk("grp_fill",  grp_fill_vld_o, fill_vld_i ? exp_hit : '0);
      chk("grp_flush", grp_flush_o, flush_i);
      chk("pick_data", pick_data_o, x_pick);
      chk("wb_valid",  wb_valid_o, e_wbg >= 0);
      chk("wb_data",   wb_data_o, x_wbd);
      chk("wb_id",     wb_id_o, x_wbi);
      chk("err",       err_o, merr);

      @(posedge clk_i);
      if (rst_ni) begin
        if (flush_i) model_clear(1'b0);
        else begin
          if (e_wbg >= 0 && wb_ready_i) begin
            void'(resq[e_wbg].pop_front());
            rr    = (e_wbg + 1) % NG;
            lockg = -1;
          end else if (e_wbg >= 0) lockg = e_wbg;
          else lockg = -1;
          for (int g = 0; g < NG; g++) begin
            if (grp_done_i[g]) begin
              if (idq[g].size() == 0) merr = 1'b1;
              else begin
                r_tmp.d  = grp_out_data_i[g];
                r_tmp.id = idq[g].pop_front();
                resq[g].push_back(r_tmp);
              end
            end
          end
          if (e_acc) idq[e_g].push_back(int'(instr_id_i));
        end
      end
    end
  end

  task automatic idle();
    exec_i     = 1'b0;
    fill_vld_i = 1'b0;
    pick_vld_i = 1'b0;
    flush_i    = 1'b0;
    wb_ready_i = 1'b0;
    grp_done_i = '0;
    opcode_i   = '0;
    instr_id_i = '0;
  endtask

  task automatic next();
    @(posedge clk_i);
    #1;
    idle();
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic issue(input int g, input int id);
    exec_i     = 1'b1;
    opcode_i   = OPW'(8 * g + 1);
    instr_id_i = IW'(id);
  endtask

  task automatic done(input int g, input logic [63:0] d);
    grp_done_i[g]     = 1'b1;
    grp_out_data_i[g] = d;
  endtask

  initial begin
    rst_ni         = 1'b0;
    grp_out_data_i = '0;
    idle();
    repeat (2) @(posedge clk_i);
    #3;
    chk("rst_wb_valid", wb_valid_o, 1'b0);
    chk("rst_err",      err_o, 1'b0);
    chk("rst_wb_id",    wb_id_o, '0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Two outstanding per group, third refused; fill ignores credits.
    next(); issue(1, 3); settle();
    chk("iss1_acc", accept_o, 1'b1); chk("iss1_exec", grp_exec_o, 4'b0010);
    next(); issue(1, 5); settle(); chk("iss2_acc", accept_o, 1'b1);
    next(); issue(1, 7); fill_vld_i = 1'b1; settle();
    chk("iss3_acc", accept_o, 1'b0); chk("iss3_exec", grp_exec_o, 4'b0000);
    chk("fill_no_credit", grp_fill_vld_o, 4'b0010);

    // In-order tagging, one cycle after each done.
    next(); done(1, 64'hA); wb_ready_i = 1'b1; settle(); chk("no_bypass", wb_valid_o, 1'b0);
    next(); done(1, 64'hB); wb_ready_i = 1'b1; settle();
    chk("wb0_data", wb_data_o, 64'hA); chk("wb0_id", wb_id_o, 3);
    next(); wb_ready_i = 1'b1; settle();
    chk("wb1_data", wb_data_o, 64'hB); chk("wb1_id", wb_id_o, 5);
    next(); settle(); chk("wb_drained", wb_valid_o, 1'b0);

    // Round-robin order and stall stability.
    next(); flush_i = 1'b1; settle(); chk("flush_fwd", grp_flush_o, 1'b1);
    next(); issue(0, 1);
    next(); issue(2, 2);
    next(); issue(3, 4);
    next(); done(0, 64'h100); done(2, 64'h200); done(3, 64'h300);
    repeat (3) begin
      next(); settle();
      chk("stall_data", wb_data_o, 64'h100); chk("stall_id", wb_id_o, 1);
    end
    next(); wb_ready_i = 1'b1; settle(); chk("rr0", wb_data_o, 64'h100);
    next(); wb_ready_i = 1'b1; settle(); chk("rr1", wb_data_o, 64'h200); chk("rr1_id", wb_id_o, 2);
    next(); wb_ready_i = 1'b1; settle(); chk("rr2", wb_data_o, 64'h300); chk("rr2_id", wb_id_o, 4);

    // Grant held on group 2 while a higher-priority group 0 result arrives.
    next(); issue(2, 6); settle(); chk("rr_drained", wb_valid_o, 1'b0);
    next(); done(2, 64'h222);
    next(); issue(0, 8); settle(); chk("lock_first", wb_id_o, 6);
    next(); done(0, 64'h111);
    next(); settle(); chk("lock_hold", wb_id_o, 6);
    next(); wb_ready_i = 1'b1; settle(); chk("lock_pop", wb_data_o, 64'h222);
    next(); wb_ready_i = 1'b1; settle(); chk("after_lock", wb_data_o, 64'h111); chk("after_lock_id", wb_id_o, 8);

    // Pick bypass and invalid opcode.
    next(); pick_vld_i = 1'b1; opcode_i = OPW'(17); grp_out_data_i[2] = 64'hDEAD; settle();
    chk("pick", pick_data_o, 64'hDEAD); chk("pick_no_wb", wb_valid_o, 1'b0);
    next(); exec_i = 1'b1; opcode_i = OPW'(40); settle();
    chk("inv", invalid_instr_o, 1'b1); chk("inv_acc", accept_o, 1'b0); chk("inv_pick", pick_data_o, '0);

    // Pop and exec to a full group in the same cycle.
    next(); issue(0, 9);
    next(); issue(0, 10);
    next(); done(0, 64'h901);
    next(); done(0, 64'h902);
    next(); wb_ready_i = 1'b1; issue(0, 11); settle();
    chk("acc_at_full", accept_o, 1'b0); chk("pop_data", wb_data_o, 64'h901);
    next(); issue(0, 11); settle(); chk("acc_after_pop", accept_o, 1'b1);
    next(); issue(0, 12); settle(); chk("acc_full_again", accept_o, 1'b0);

    // Flush with three buffered results; a done during flush is ignored.
    next(); issue(2, 13);
    next(); done(0, 64'h903); done(2, 64'h913);
    next(); settle(); chk("pre_flush_wb", wb_valid_o, 1'b1);
    flush_i = 1'b1; grp_done_i[3] = 1'b1; settle(); chk("flush_wb", wb_valid_o, 1'b0);
    next(); issue(0, 1); settle();
    chk("post_flush_wb", wb_valid_o, 1'b0); chk("post_flush_err", err_o, 1'b0);
    chk("post_flush_acc0", accept_o, 1'b1);
    next(); issue(0, 2); settle(); chk("post_flush_acc1", accept_o, 1'b1);

    // Done with no pending ID: sticky error until reset.
    next(); done(1, 64'h55);
    next(); settle(); chk("err_set", err_o, 1'b1);
    repeat (2) next();
    settle(); chk("err_sticky", err_o, 1'b1);
    next(); rst_ni = 1'b0; settle();
    chk("err_rst", err_o, 1'b0); chk("rst_wb", wb_valid_o, 1'b0);
    next(); rst_ni = 1'b1;
    repeat (2) next();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/group_dispatcher.md
# group_dispatcher

Parametrised dispatcher between the CV-X-IF issue/commit logic and `NumGroup` coprocessor execution groups. It replaces single-outstanding, busy-gated dispatch with the following:
- per-group credit tracking for up to `MaxOutstanding` in-flight instructions;
- per-group buffering of results tagged with their instruction IDs;
- round-robin result writeback with a valid/ready handshake to the core;
- a separate combinational pick path;
- a synchronous flush.

## Interface
- `NumGroup`, 4: number of execution groups (≥1).
- `OpcodeWidth`, 6: width of the internal opcode.
- `OutWidth`, 64: width of group result data.
- `IdWidth`, `X_ID_WIDTH`: width of the instruction ID.
- `MaxOutstanding`, 2: per-group credit limit (≥1). It also sets the depth of both the ID FIFO and the result FIFO.
- `OpcodeBound`, {0,8,16,24,32}: `NumGroup+1` ascending bounds. Group g owns opcodes in [`OpcodeBound[g]`, `OpcodeBound[g+1]`).
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: kill all outstanding work.
- `exec_i` in 1: issue request.
- `opcode_i` in `OpcodeWidth`: opcode of the current request.
- `instr_id_i` in `IdWidth`: ID of the current request.
- `fill_vld_i` in 1: operand fill for the decoded group.
- `pick_vld_i` in 1: result pick from the decoded group.
- `accept_o` out 1: the issue is accepted this cycle.
- `invalid_instr_o` out 1: the opcode maps to no group.
- `grp_exec_o` out `NumGroup`: one-hot execute strobe to the groups.
- `grp_fill_vld_o` out `NumGroup`: one-hot fill strobe.
- `grp_flush_o` out 1: `flush_i` forwarded to the groups.
- `grp_done_i` in `NumGroup`: per-group completion pulse.
- `grp_out_data_i` in `NumGroup`×`OutWidth`: per-group result data.
- `pick_data_o` out `OutWidth`: combinational pick data.
- `wb_valid_o` out 1: a writeback is pending.
- `wb_ready_i` in 1: the core accepts the writeback.
- `wb_data_o` out `OutWidth`: writeback data.
- `wb_id_o` out `IdWidth`: writeback instruction ID.
- `err_o` out 1: sticky protocol error.

## Operation
- **Decode.**
  - `hit[g]` is true when `OpcodeBound[g] ≤ opcode_i < OpcodeBound[g+1]`.
  - `invalid_instr_o` = no hit, i.e. `opcode_i ≥ OpcodeBound[NumGroup]` or `opcode_i < OpcodeBound[0]`.
- **Credits.**
  - `cnt[g]` = IDs pending in the ID FIFO + results held in the result FIFO. Range 0..`MaxOutstanding`.
  - `accept_o` = `exec_i` && hit && `cnt[g] < MaxOutstanding` && !`flush_i`.
  - `grp_exec_o[g]` = `accept_o` && `hit[g]`.
  - An `exec_i` that is not accepted is dropped. The core must retry it.
- **ID FIFO.** On accept, push `instr_id_i`. On `grp_done_i[g]`, pop the head ID and push {`grp_out_data_i[g]`, head ID} into the result FIFO.
- **Done with empty ID FIFO.** The pulse is dropped and `err_o` is set. `err_o` stays set until reset.
- **Fill.**
  - `grp_fill_vld_o[g]` = `fill_vld_i` && `hit[g]`.
  - Fill is independent of credits.
- **Pick.**
  - `pick_data_o` = `grp_out_data_i[decoded g]`.
  - When there is no hit, `pick_data_o` is 0.
  - A pick never touches the FIFOs or the writeback path.
- **Writeback.**
  - Round-robin arbitration runs over non-empty result FIFOs. `wb_valid_o` is high when any result FIFO is non-empty.
  - The grant is locked while `wb_valid_o` && !`wb_ready_i`. `wb_data_o`/`wb_id_o` must stay stable under the lock.
  - On handshake: pop the granted result FIFO, decrement `cnt[g]`, and move the RR priority past g.
- **Simultaneous events.**
  - Accept and done on the same group in the same cycle: both are legal.
  - Accept and writeback pop on the same group: `cnt` is net unchanged.
  - Done on a full result FIFO cannot happen, because credits bound occupancy.
- **Flush.**
  - `flush_i` clears, on the next edge: all FIFOs, all `cnt`, and the RR state.
  - `grp_flush_o` = `flush_i`.
  - During the flush cycle, `wb_valid_o` is forced to 0 and `grp_done_i` is ignored with no error.
  - After the flush, groups must not report stale dones.

## Timing
- **Reset values.** All FIFOs empty, `cnt` = 0, RR pointer 0. As a result `wb_valid_o`=0, `err_o`=0, `wb_data_o`/`wb_id_o`=0, `grp_*`=0 with inputs idle.
- **Issue.** `accept_o`, `grp_exec_o`, `grp_fill_vld_o`, `invalid_instr_o` and `pick_data_o` are combinational in the same cycle as the request.
- **Writeback latency.** `grp_done_i` at edge t → `wb_valid_o` from cycle t+1. The result FIFO is registered, with no done-to-wb bypass.
- **Throughput.** One writeback per cycle when `wb_ready_i` is held high.
- **Credit release.** A credit freed by a handshake at edge t is visible to `accept_o` in cycle t+1.
- **Reset mid-operation.** Asynchronous clear of all state. In-flight results are lost.

## Structure
- **Shared package** (`cvxif_instr_pkg`): add a `group_result_t` struct {out_data, instr_id}, parametrised via the module type parameter, and a `group_cnt_t` width helper, `$clog2(MaxOutstanding+1)`.
- **Sub-module `group_result_fifo`**:
  - one per group;
  - holds the ID FIFO plus the result FIFO (depth `MaxOutstanding`);
  - provides `cnt` and `err`.
- **Arbiter**: common-cells `rr_arb_tree` with `LockIn=1`.

## Test plan
- **Multiple outstanding per group.** `MaxOutstanding`=2. Issue IDs 3, 5 to group 1 on back-to-back cycles → both accepted. A third issue, ID 7, in the next cycle → `accept_o`=0 and `grp_exec_o`=0.
- **In-order tagging.** Group 1 done ×2 with data 0xA, then 0xB, and `wb_ready_i`=1 → writebacks (0xA, 3) then (0xB, 5) on consecutive cycles, each one cycle after its done.
- **Round-robin and lock.**
  - Groups 0, 2, 3 each hold one result and `wb_ready_i`=0 for 3 cycles → `wb_data_o`/`wb_id_o` stay constant throughout.
  - Then ready=1 → writeback order 0, 2, 3.
- **Pick bypass and invalid opcode.**
  - `pick_vld_i` with an opcode in group 2 → `pick_data_o` = `grp_out_data_i[2]` in the same cycle, and the FIFOs are unchanged.
  - Opcode 40 → `invalid_instr_o`=1 and `accept_o`=0.
- **Simultaneous accept and pop.** Group 0 has `cnt`=2, and a writeback pop coincides with an exec to group 0 → the exec is rejected (cnt was 2 that cycle). The next-cycle exec is accepted, and `cnt` stays 2.
- **Flush and error.**
  - Flush with 3 results buffered → `wb_valid_o`=0 in the following cycle, all `cnt`=0.
  - Then `grp_done_i[1]` with no pending ID → `err_o`=1 and stays high until `rst_ni` is asserted.
